oam_dma: RTL and testbench
==========================

# oam_dma

Sprite-attribute DMA engine on the CPU bus, directly downstream of `cpu_top`. A CPU write to the trigger register starts the engine. The engine then stalls the CPU through `rdy` and takes over the address/data bus. It copies one 256-byte page of `mem` into the PPU OAM data port, one byte per read/write cycle pair. The top level muxes `A`, `D` and `R_W_n` from this block whenever `dma_active` is high.

## Interface
- `ADDR_WIDTH`, 16, bus address width
- `REG_WIDTH`, 8, data width
- `TRIGGER_ADDR`, 16'h4014, CPU write address that starts a transfer
- `OAM_DATA_ADDR`, 16'h2004, destination address written every WRITE cycle
- `phi0`  in  1  clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `cpu_addr`  in  16  CPU address bus (`A` as driven by cpu)
- `cpu_d_out`  in  8  CPU write data
- `cpu_r_w_n`  in  1  CPU read/write strobe (1 = read)
- `mem_d_in`  in  8  read data returned from `mem`
- `rdy`  out  1  CPU ready; 0 stalls CPU
- `dma_active`  out  1  block owns the bus this cycle
- `dma_addr`  out  16  bus address while active
- `dma_r_w_n`  out  1  bus strobe while active
- `dma_d_out`  out  8  bus write data while active

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- Trigger event: rising edge in IDLE with `cpu_r_w_n`=0 and `cpu_addr`=`TRIGGER_ADDR`.
  - On that edge, `page` latches `cpu_d_out`, `idx` clears to 0, and the state moves to HALT.
- Triggers seen in any state other than IDLE are ignored; `page` is unchanged.
- HALT:
  - `rdy`=0.
  - The 6502 ignores RDY on write cycles, so HALT holds while `cpu_r_w_n`=0.
  - Once `cpu_r_w_n`=1, the next state is ALIGN if `parity`=1, else READ.
- ALIGN: `rdy`=0; the bus stays with the CPU; goes to READ.
- READ:
  - `dma_active`=1, `dma_r_w_n`=1, `dma_addr`={`page`,`idx`}.
  - `mem_d_in` latches into `data_q` at the end of the cycle.
  - Goes to WRITE.
- WRITE:
  - `dma_active`=1, `dma_r_w_n`=0, `dma_addr`=`OAM_DATA_ADDR`, `dma_d_out`=`data_q`.
  - `idx` increments as 8 bits.
  - If `idx` was 8'hFF, go to IDLE; else go to READ.
- `parity`: a 1-bit free-running toggle on every `phi0` edge; it is 0 on the first edge after reset release.
- `idx` wraps inside the page: page 8'hFF reads 16'hFF00–16'hFFFF and never carries into the page bits.
- `rdy` returns to 1 in the same cycle the state returns to IDLE.

## Timing
- Reset values:
  - `rdy`=1, `dma_active`=0, `dma_addr`=0, `dma_r_w_n`=1, `dma_d_out`=0.
  - State IDLE; `page`, `idx`, `data_q` and `parity` all 0.
- Reset is asynchronous. Asserting it mid-transfer abandons the transfer immediately, with no completion of the current byte.
- Cycle T is the trigger write cycle.
  - T+1 is HALT (`rdy` low).
  - The first READ is T+2, or T+3 if ALIGN is inserted.
- Stall length, with no extra write cycles in HALT:
  - 1 + 512 = 513 cycles of `rdy`=0 when no ALIGN is inserted.
  - 514 cycles when ALIGN is inserted.
- Each extra CPU write cycle during HALT adds one cycle.
- Outputs are registered from state and are glitch-free relative to `phi0`.
- `mem` read data is valid before the end of the READ cycle; `mem` is clocked on !`phi0`.

## Structure
- Put in PKG/pkg.v:
  - `` `OAM_DMA_ADDR `` and `` `OAM_DATA_ADDR `` defines.
  - `dma_state_t` enum typedef: IDLE, HALT, ALIGN, READ, WRITE.
- Single module, with no sub-modules.
- The bus mux between `cpu_top` and `oam_dma` is one level up, in the system top.

## Test plan
- Reset: hold `reset_n`=0 for 10 cycles → `rdy`=1, `dma_active`=0, `dma_addr`=16'h0000, `dma_r_w_n`=1.
- Even start:
  - Stimulus: mem[16'h0200+i]=i^8'hA5; CPU writes 8'h02 to 16'h4014 with `parity` giving no ALIGN.
  - Required: 256 writes to 16'h2004 carrying i^8'hA5 in order; address sequence 0200, 2004, 0201, …, 02FF, 2004; `rdy` low exactly 513 cycles.
- Odd start: same as Even start, but the trigger lands one cycle later → ALIGN is inserted; `rdy` low exactly 514 cycles; data identical.
- Page wrap: trigger with 8'hFF → last read address 16'hFFFF; no access to 16'h0000; returns to IDLE.
- Retrigger ignored: a second write of 8'h05 to 16'h4014 during byte 40 → remaining bytes still read from page 8'h02; no restart.
- Reset mid-transfer:
  - Assert `reset_n`=0 during byte 100 → `rdy`=1 and `dma_active`=0 asynchronously.
  - After release, no further writes to 16'h2004.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// oam_dma_pkg: shared definitions for the sprite-attribute DMA engine.
//   - bus address defines for the trigger register and the OAM data port
//   - dma_state_t: engine state encoding
//   - default address/width constants used as module parameter defaults
`ifndef OAM_DMA_PKG_DEFS
`define OAM_DMA_PKG_DEFS
`define OAM_DMA_ADDR  16'h4014
`define OAM_DATA_ADDR 16'h2004
`endif

package oam_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  // Byte index within the 256-byte source page.
  localparam int IDX_WIDTH = 8;

  localparam logic [15:0] TRIGGER_ADDR_DEFAULT  = `OAM_DMA_ADDR;
  localparam logic [15:0] OAM_DATA_ADDR_DEFAULT = `OAM_DATA_ADDR;

endpackage

// File: rtl/oam_dma.sv
// oam_dma: copies one 256-byte page of memory into the PPU OAM data port.
// A CPU write of the page number to the trigger address starts the engine;
// the CPU is stalled through rdy while the engine owns the bus, alternating
// one READ cycle ({page, idx}) with one WRITE cycle (OAM data port).
//
// Ports:
//   phi0        clock, all state changes on the rising edge
//   reset_n     asynchronous active-low reset
//   cpu_addr    CPU address bus
//   cpu_d_out   CPU write data (page number on trigger)
//   cpu_r_w_n   CPU read/write strobe, 1 = read
//   mem_d_in    read data returned by memory during READ
//   rdy         CPU ready, 0 stalls the CPU
//   dma_active  engine owns the bus this cycle
//   dma_addr    bus address while active
//   dma_r_w_n   bus strobe while active
//   dma_d_out   bus write data while active
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 16,
  parameter int                    REG_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] TRIGGER_ADDR  = ADDR_WIDTH'(TRIGGER_ADDR_DEFAULT),
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = ADDR_WIDTH'(OAM_DATA_ADDR_DEFAULT)
) (
  input  logic                  phi0,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [REG_WIDTH-1:0]  cpu_d_out,
  input  logic                  cpu_r_w_n,
  input  logic [REG_WIDTH-1:0]  mem_d_in,
  output logic                  rdy,
  output logic                  dma_active,
  output logic [ADDR_WIDTH-1:0] dma_addr,
  output logic                  dma_r_w_n,
  output logic [REG_WIDTH-1:0]  dma_d_out
);

  dma_state_t            state_q, state_d;
  logic [REG_WIDTH-1:0]  page_q, page_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [REG_WIDTH-1:0]  data_q, data_d;
  logic                  parity_q, parity_d;

  // Bus-facing outputs are registered from the next state so they change
  // only on the clock edge, in step with the state they describe.
  logic                  rdy_q, rdy_d;
  logic                  active_q, active_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  r_w_n_q, r_w_n_d;
  logic [REG_WIDTH-1:0]  d_out_q, d_out_d;

  logic trigger;
  assign trigger = !cpu_r_w_n && (cpu_addr == TRIGGER_ADDR);

  // Next-state logic.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred; blocking '=' is correct in
  // combinational code, while the flop block below uses '<=' only.
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    data_d   = data_q;
    parity_d = ~parity_q;

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          page_d  = cpu_d_out;
          idx_d   = '0;
          state_d = HALT;
        end
      end
      HALT: begin
        // The CPU cannot be stopped on a write cycle; wait for a read.
        if (cpu_r_w_n) begin
          state_d = parity_q ? ALIGN : READ;
        end
      end
      ALIGN: begin
        state_d = READ;
      end
      READ: begin
        data_d  = mem_d_in;
        state_d = WRITE;
      end
      WRITE: begin
        // idx wraps inside the page; it never carries into the page bits.
        idx_d   = idx_q + IDX_WIDTH'(1);
        state_d = (idx_q == '1) ? IDLE : READ;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values for the cycle that state_d describes.
  always_comb begin
    rdy_d    = (state_d == IDLE);
    active_d = (state_d == READ) || (state_d == WRITE);
    r_w_n_d  = (state_d != WRITE);
    addr_d   = '0;
    d_out_d  = '0;
    if (state_d == READ) begin
      addr_d = ADDR_WIDTH'({page_d, idx_d});
    end else if (state_d == WRITE) begin
      addr_d  = OAM_DATA_ADDR;
      d_out_d = data_d;
    end
  end

  always_ff @(posedge phi0 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      page_q   <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
      rdy_q    <= 1'b1;
      active_q <= 1'b0;
      addr_q   <= '0;
      r_w_n_q  <= 1'b1;
      d_out_q  <= '0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      parity_q <= parity_d;
      rdy_q    <= rdy_d;
      active_q <= active_d;
      addr_q   <= addr_d;
      r_w_n_q  <= r_w_n_d;
      d_out_q  <= d_out_d;
    end
  end

  assign rdy        = rdy_q;
  assign dma_active = active_q;
  assign dma_addr   = addr_q;
  assign dma_r_w_n  = r_w_n_q;
  assign dma_d_out  = d_out_q;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized scoreboard bench for oam_dma.
// The bench plays CPU and memory. Each trigger pushes the full expected bus
// access list for the page and the expected stall length; a monitor on the
// falling edge pops and compares every bus cycle the DUT drives.
module tb_oam_dma;

  logic        phi0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_r_w_n;
  logic [7:0]  mem_d_in;
  logic        rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_r_w_n;
  logic [7:0]  dma_d_out;

  oam_dma dut (
    .phi0       (phi0),
    .reset_n    (reset_n),
    .cpu_addr   (cpu_addr),
    .cpu_d_out  (cpu_d_out),
    .cpu_r_w_n  (cpu_r_w_n),
    .mem_d_in   (mem_d_in),
    .rdy        (rdy),
    .dma_active (dma_active),
    .dma_addr   (dma_addr),
    .dma_r_w_n  (dma_r_w_n),
    .dma_d_out  (dma_d_out)
  );

  initial phi0 = 1'b0;
  always #5 phi0 = ~phi0;

  typedef struct {
    logic [15:0] addr;
    logic        r_w_n;
    logic [7:0]  data;
  } acc_t;

  logic [7:0] mem [0:65535];
  acc_t       exp_q[$];
  int         stall_q[$];
  int         tests = 0;
  int         fails = 0;
  int         edge_cnt;
  int         writes_seen = 0;
  int         rdy_low = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory answers on the falling edge, inside the READ cycle.
  initial mem_d_in = 8'h00;
  always @(negedge phi0) begin
    if (dma_active && dma_r_w_n) mem_d_in <= mem[dma_addr];
  end

  // Edge j after reset release sees parity = j mod 2.
  always @(posedge phi0 or negedge reset_n) begin
    if (!reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;
  end

  // Monitor: compares every DUT bus cycle and every stall run.
  always @(negedge phi0) begin
    acc_t e;
    if (!reset_n) begin
      rdy_low = 0;
    end else begin
      if (dma_active) begin
        if (!dma_r_w_n && dma_addr == 16'h2004) writes_seen++;
        if (exp_q.size() == 0) begin
          check("spurious_access", dma_active, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("bus_addr", dma_addr, e.addr);
          check("bus_r_w_n", dma_r_w_n, e.r_w_n);
          if (!e.r_w_n) check("bus_data", dma_d_out, e.data);
        end
      end
      if (!rdy) begin
        rdy_low++;
      end else if (rdy_low > 0) begin
        if (stall_q.size() == 0) check("spurious_stall", rdy_low, 0);
        else                     check("stall_len", rdy_low, stall_q.pop_front());
        rdy_low = 0;
      end
    end
  end

  // One transfer. want_align selects whether the trigger lands so that
  // ALIGN is inserted; n_extra CPU writes follow the trigger in HALT;
  // retrig writes page 8'h05 to the trigger during byte 40; abort resets
  // the engine during byte 100.
  task automatic run_dma(input logic [7:0] page, input bit want_align,
                         input int n_extra, input bit retrig, input bit abort);
    int k;
    bit align;
    bit done;
    int snap;
    @(negedge phi0);
    while (((edge_cnt + 1 + n_extra) % 2) != int'(want_align)) @(negedge phi0);
    k = edge_cnt;
    cpu_addr  = 16'h4014;
    cpu_r_w_n = 1'b0;
    cpu_d_out = page;
    align = ((k + 1 + n_extra) % 2) == 1;
    for (int i = 0; i < 256; i++) begin
      logic [15:0] a;
      a = {page, 8'(i)};
      exp_q.push_back('{a, 1'b1, 8'h00});
      exp_q.push_back('{16'h2004, 1'b0, mem[a]});
    end
    stall_q.push_back(1 + n_extra + int'(align) + 512);
    for (int i = 0; i < n_extra; i++) begin
      @(negedge phi0);
      cpu_addr  = 16'h0100;
      cpu_r_w_n = 1'b0;
      cpu_d_out = 8'h33;
    end
    @(negedge phi0);
    cpu_addr  = 16'h0000;
    cpu_r_w_n = 1'b1;
    if (retrig) begin
      repeat (int'(align) + 80) @(negedge phi0);
      cpu_addr  = 16'h4014;
      cpu_r_w_n = 1'b0;
      cpu_d_out = 8'h05;
      @(negedge phi0);
      cpu_addr  = 16'h0000;
      cpu_r_w_n = 1'b1;
    end
    if (abort) begin
      repeat (int'(align) + 200) @(negedge phi0);
      #2 reset_n = 1'b0;
      #1;
      check("abort_rdy", rdy, 1'b1);
      check("abort_active", dma_active, 1'b0);
      check("abort_addr", dma_addr, 16'h0000);
      check("abort_r_w_n", dma_r_w_n, 1'b1);
      exp_q.delete();
      stall_q.delete();
      repeat (3) @(negedge phi0);
      reset_n = 1'b1;
      snap = writes_seen;
      repeat (600) @(negedge phi0);
      check("writes_after_abort", writes_seen - snap, 0);
      check("rdy_after_abort", rdy, 1'b1);
      return;
    end
    done = 1'b0;
    for (int c = 0; c < 1200 && !done; c++) begin
      @(negedge phi0);
      if (rdy && exp_q.size() == 0) done = 1'b1;
    end
    check("done_in_time", done, 1'b1);
    @(negedge phi0);
    check("exp_queue_drained", exp_q.size(), 0);
    check("stall_queue_drained", stall_q.size(), 0);
    check("idle_active", dma_active, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

    reset_n   = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_d_out = 8'h00;
    cpu_r_w_n = 1'b1;
    repeat (10) @(negedge phi0);
    check("reset_rdy", rdy, 1'b1);
    check("reset_active", dma_active, 1'b0);
    check("reset_addr", dma_addr, 16'h0000);
    check("reset_r_w_n", dma_r_w_n, 1'b1);
    check("reset_d_out", dma_d_out, 8'h00);
    reset_n = 1'b1;
    repeat (3) @(negedge phi0);

    run_dma(8'h02, 1'b0, 0, 1'b0, 1'b0);   // even start, 513-cycle stall
    run_dma(8'h02, 1'b1, 0, 1'b0, 1'b0);   // odd start, ALIGN inserted
    run_dma(8'hFF, 1'b0, 0, 1'b0, 1'b0);   // page wrap at 16'hFFFF
    run_dma(8'h02, 1'b1, 0, 1'b1, 1'b0);   // retrigger ignored
    run_dma(8'($urandom), 1'($urandom), int'($urandom_range(1, 3)), 1'b0, 1'b0);
    run_dma(8'($urandom), 1'($urandom), 0, 1'b0, 1'b0);
    run_dma(8'($urandom), 1'($urandom), int'($urandom_range(1, 3)), 1'b1, 1'b0);
    run_dma(8'h02, 1'b0, 0, 1'b0, 1'b1);   // reset during byte 100

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
